wb_mtimer: RTL and testbench
============================

// Module: wb_mtimer
// PURPOSE
//  RISC-V machine timer (mtime/mtimecmp) exposed as a pipelined Wishbone slave.
//  Sits downstream of the wishbone interconnect on one of its slave ports.
//  Provides a free-running 64-bit counter with a programmable prescaler and a
//  level timer interrupt (mtime >= mtimecmp) routed to the core's MTIP input.
// PARAMETERS
//  DEFAULT_PRESCALE  16'd0  CTRL.PRESCALE reset value; the counter ticks every PRESCALE+1 clocks.
//  RESET_ENABLE      1'b1   CTRL.EN reset value.
// PORTS
//  clk_i        in      1    system clock; only clock domain.
//  rstn_i       in      1    reset, synchronous, active-low.
//  wb_if        SLAVE   -    wishbone_if.SLAVE: cyc stb we addr[31:0] sel[3:0] wdata[31:0] / rdata ack err rty stall.
//  timer_irq_o  out     1    machine timer interrupt, level, registered.
// BEHAVIOUR
//  Register map (word index = addr[4:2]; upper address bits are ignored because decode is upstream):
//   0 MTIME_LO rw | 1 MTIME_HI rw | 2 MTIMECMP_LO rw | 3 MTIMECMP_HI rw
//   4 CTRL rw: [0] EN, [31:16] PRESCALE, other bits read 0 | 5..7 unmapped: read 0, writes ignored.
//  Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL={DEFAULT_PRESCALE,RESET_ENABLE},
//   presc_cnt=0, rdata=0, ack=0, timer_irq_o=0.
//  Handshake:
//   - stall tied 0, err=0, rty=0.
//   - A request is accepted in every cycle with cyc&stb, and back-to-back requests are supported.
//   - ack is asserted exactly 1 cycle after acceptance, with registered rdata, and lasts 1 cycle per request.
//   - If cyc is low in the ack cycle, ack is forced low and the request is dropped.
//   - Unmapped accesses are still acked so the master never hangs.
//  Writes:
//   - Applied at the acceptance edge, with byte lanes gated by sel[i] -> bits [8i+7:8i].
//   - sel=0 writes nothing but is still acked.
//  Reads: return the register value present in the acceptance cycle (pre-write/pre-tick).
//  Prescaler:
//   - When EN=1, presc_cnt counts 0..PRESCALE. On presc_cnt==PRESCALE it emits tick and wraps to 0.
//   - When EN=0, presc_cnt holds, no tick occurs, and mtime holds.
//   - A CTRL write that changes PRESCALE also clears presc_cnt.
//   - A new PRESCALE below the current count takes effect without overshoot.
//  mtime:
//   - Increments by 1 on each tick, wrapping 64'hFFFF..FF -> 0 with no flag.
//   - A write to MTIME_LO/HI wins over a same-cycle tick; the written half takes wdata and the
//     other half keeps its pre-tick value. No carry is applied that cycle.
//   - Only the written half changes; no hi/lo latching (software does a hi-lo-hi read loop).
//  Interrupt:
//   - timer_irq_o <= (mtime >= mtimecmp), 64-bit unsigned compare.
//   - It is registered, so it follows a counter/compare change by 1 cycle.
//   - The interrupt is cleared only by raising mtimecmp or lowering mtime; there is no sticky bit.
//  Reset mid-transaction: an in-flight ack is dropped; all state returns to reset values.
// STRUCTURE
//  Package wb_mtimer_pkg:
//   - Register index localparams: MTIME_LO=3'd0..CTRL=3'd4.
//   - CTRL field positions: EN_BIT=0, PRESC_LSB=16.
//   - typedef ctrl_t (packed struct: prescale[15:0], rsvd[14:0], en).
//  Sub-module mtimer_prescaler (en_i, prescale_i, clear_i -> tick_o) holds presc_cnt.
//  Top level holds register file, byte-lane write merge, read mux, ack pipe and compare.
// TESTING
//  1. Reset, read all 5 regs -> 0, 0, FFFFFFFF, FFFFFFFF, {DEFAULT_PRESCALE,15'b0,1}; irq=0; each ack 1 cycle after stb.
//  2. PRESCALE=3, EN=1, idle 40 clocks -> MTIME_LO=10 (+/-1 from write alignment); PRESCALE=0 -> +1 per clock.
//  3. MTIME_LO=FFFFFFFF, MTIME_HI=0, one tick -> HI=1, LO=0. Write LO coincident with tick -> LO=written value, HI unchanged.
//  4. MTIMECMP=mtime+5 -> irq rises 1 clock after mtime reaches cmp; MTIMECMP=FFFF.. -> irq low next+1 cycle.
//  5. sel=4'b0010, wdata=32'hAABBCCDD to MTIMECMP_LO=0 -> reads 0000CC00; unmapped addr 0x18 -> acked, rdata 0.
//  6. 4 back-to-back stb with stall=0 -> 4 consecutive acks; cyc dropped before ack -> no ack; rstn_i low mid-run -> reset values.

Source files
------------

// File: rtl/wb_mtimer_pkg.sv
// Shared register map, CTRL layout and byte-lane helper for the machine timer.
package wb_mtimer_pkg;

  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CTRL        = 3'd4;

  localparam int EN_BIT    = 0;
  localparam int PRESC_LSB = 16;

  typedef struct packed {
    logic [15:0] prescale;
    logic [14:0] rsvd;
    logic        en;
  } ctrl_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides the system clock into mtime ticks: one tick every prescale_i+1 enabled clocks.
module mtimer_prescaler (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic [15:0] prescale_i,
  input  logic        clear_i,
  output logic        tick_o
);

  logic [15:0] presc_cnt;

  // >= rather than == so a count already past a lowered limit wraps at once.
  assign tick_o = en_i && (presc_cnt >= prescale_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      presc_cnt <= 16'd0;
    end else if (clear_i || tick_o) begin
      presc_cnt <= 16'd0;
    end else if (en_i) begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/wb_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) behind a pipelined Wishbone slave port.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd0,
  parameter logic        RESET_ENABLE     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_addr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_rty,
  output logic        wb_stall,
  output logic        timer_irq_o
);

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  ctrl_t       ctrl_q;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic        irq_q;

  logic        req;
  logic        wr;
  logic [2:0]  idx;
  logic        tick;
  logic        presc_clear;
  logic [31:0] rd_val;
  ctrl_t       ctrl_wr;
  logic [63:0] mtime_nxt;
  logic        unused_addr_bits;

  assign req = wb_cyc & wb_stb;
  assign wr  = req & wb_we;
  assign idx = wb_addr[4:2];
  assign unused_addr_bits = ^{wb_addr[31:5], wb_addr[1:0]};

  always_comb begin
    rd_val = 32'd0;
    case (idx)
      MTIME_LO:    rd_val = mtime_q[31:0];
      MTIME_HI:    rd_val = mtime_q[63:32];
      MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      CTRL:        rd_val = ctrl_q;
      default:     rd_val = 32'd0;
    endcase
  end

  always_comb begin
    logic [31:0] merged;
    merged           = merge_bytes(ctrl_q, wb_wdata, wb_sel);
    ctrl_wr          = '0;
    ctrl_wr.prescale = merged[PRESC_LSB +: 16];
    ctrl_wr.en       = merged[EN_BIT];
  end

  assign presc_clear = wr && (idx == CTRL) && (ctrl_wr.prescale != ctrl_q.prescale);

  mtimer_prescaler u_prescaler (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (ctrl_q.en),
    .prescale_i (ctrl_q.prescale),
    .clear_i    (presc_clear),
    .tick_o     (tick)
  );

  // A bus write to either half overrides the tick; the other half keeps its pre-tick value.
  always_comb begin
    mtime_nxt = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr && idx == MTIME_LO) begin
      mtime_nxt = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_wdata, wb_sel)};
    end else if (wr && idx == MTIME_HI) begin
      mtime_nxt = {merge_bytes(mtime_q[63:32], wb_wdata, wb_sel), mtime_q[31:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      ctrl_q     <= '{prescale: DEFAULT_PRESCALE, rsvd: '0, en: RESET_ENABLE};
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q <= mtime_nxt;
      irq_q   <= (mtime_q >= mtimecmp_q);
      ack_q   <= req;
      if (req) rdata_q <= rd_val;
      if (wr && idx == MTIMECMP_LO)
        mtimecmp_q[31:0] <= merge_bytes(mtimecmp_q[31:0], wb_wdata, wb_sel);
      if (wr && idx == MTIMECMP_HI)
        mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], wb_wdata, wb_sel);
      if (wr && idx == CTRL) ctrl_q <= ctrl_wr;
    end
  end

  // A master that abandons the cycle never sees the pending ack.
  assign wb_ack      = ack_q & wb_cyc;
  assign wb_rdata    = rdata_q;
  assign wb_err      = 1'b0;
  assign wb_rty      = 1'b0;
  assign wb_stall    = 1'b0;
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed bench for wb_mtimer with a cycle-level reference model checked on every negedge.
module tb_wb_mtimer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic        ack, err, rty, stall, irq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_mtimer #(.DEFAULT_PRESCALE(16'd0), .RESET_ENABLE(1'b1)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .wb_cyc      (cyc),
    .wb_stb      (stb),
    .wb_we       (we),
    .wb_addr     (addr),
    .wb_sel      (sel),
    .wb_wdata    (wdata),
    .wb_rdata    (rdata),
    .wb_ack      (ack),
    .wb_err      (err),
    .wb_rty      (rty),
    .wb_stall    (stall),
    .timer_irq_o (irq)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: timer value, compare value, prescaler phase and bus response.
  logic [63:0] m_time, m_cmp;
  logic [15:0] m_presc, m_cnt;
  logic        m_en, m_ack, m_irq;
  logic [31:0] m_rdata;
  bit          model_ok = 0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelRead(input int i);
    case (i)
      0: return m_time[31:0];
      1: return m_time[63:32];
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {m_presc, 15'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int          i;
    logic        tick;
    logic [63:0] nt;
    logic [31:0] c;
    if (!rstn) begin
      m_time = 64'd0; m_cmp = '1; m_presc = 16'd0; m_en = 1'b1; m_cnt = 16'd0;
      m_ack = 1'b0; m_irq = 1'b0; m_rdata = 32'd0;
      model_ok = 1;
    end else begin
      i     = int'(addr[4:2]);
      tick  = m_en && (m_cnt == m_presc);
      nt    = tick ? m_time + 64'd1 : m_time;
      m_irq = (m_time >= m_cmp);
      if (cyc && stb) m_rdata = modelRead(i);
      m_ack = cyc && stb;
      if (m_en) m_cnt = tick ? 16'd0 : m_cnt + 16'd1;
      if (cyc && stb && we) begin
        case (i)
          0: nt = {m_time[63:32], lanes(m_time[31:0], wdata, sel)};
          1: nt = {lanes(m_time[63:32], wdata, sel), m_time[31:0]};
          2: m_cmp[31:0]  = lanes(m_cmp[31:0], wdata, sel);
          3: m_cmp[63:32] = lanes(m_cmp[63:32], wdata, sel);
          4: begin
            c = lanes({m_presc, 15'd0, m_en}, wdata, sel);
            if (c[31:16] != m_presc) m_cnt = 16'd0;
            m_presc = c[31:16];
            m_en    = c[0];
          end
          default: ;
        endcase
      end
      m_time = nt;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("ack", {63'd0, ack}, {63'd0, m_ack && cyc});
      if (m_ack && cyc) checkOutput("rdata", {32'd0, rdata}, {32'd0, m_rdata});
      checkOutput("irq", {63'd0, irq}, {63'd0, m_irq});
      checkOutput("err_rty_stall", {61'd0, err, rty, stall}, 64'd0);
    end
  end

  // Burst table: entries are issued on consecutive cycles.
  logic        b_we[8];
  logic [31:0] b_addr[8], b_wdata[8];
  logic [3:0]  b_sel[8];
  logic [31:0] r_data[8];
  int          acks_seen;

  task automatic setOp(input int i, input logic w, input logic [2:0] reg_idx,
                       input logic [3:0] s, input logic [31:0] d);
    b_we[i]    = w;
    b_addr[i]  = 32'h4000_0000 | {27'd0, reg_idx, 2'b00};
    b_sel[i]   = s;
    b_wdata[i] = d;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input int n);
    acks_seen = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        cyc = 1'b1; stb = 1'b1; we = b_we[i]; addr = b_addr[i];
        sel = b_sel[i]; wdata = b_wdata[i];
      end else begin
        stb = 1'b0; we = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        if (ack) acks_seen++;
        r_data[i-1] = rdata;
      end
      @(posedge clk); #1;
    end
    cyc = 1'b0;
  endtask

  int cnt;

  initial begin
    rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = 32'd0; sel = 4'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    $display("[TB] reset values");
    for (int i = 0; i < 5; i++) setOp(i, 1'b0, 3'(i), 4'hF, 32'd0);
    applyStimulus(5);
    checkOutput("rst_mtime_lo", {32'd0, r_data[0]}, 64'h0);
    checkOutput("rst_mtime_hi", {32'd0, r_data[1]}, 64'h0);
    checkOutput("rst_cmp_lo",   {32'd0, r_data[2]}, 64'hFFFF_FFFF);
    checkOutput("rst_cmp_hi",   {32'd0, r_data[3]}, 64'hFFFF_FFFF);
    checkOutput("rst_ctrl",     {32'd0, r_data[4]}, 64'h0000_0001);
    checkOutput("rst_acks",     64'(acks_seen), 64'd5);

    $display("[TB] carry from lo to hi");
    setOp(0, 1'b1, 3'd4, 4'hF, 32'h0000_0000);
    setOp(1, 1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF);
    setOp(2, 1'b1, 3'd1, 4'hF, 32'h0000_0000);
    setOp(3, 1'b1, 3'd4, 4'hF, 32'h0000_0001);
    setOp(4, 1'b1, 3'd4, 4'hF, 32'h0000_0000);
    setOp(5, 1'b0, 3'd1, 4'hF, 32'd0);
    setOp(6, 1'b0, 3'd0, 4'hF, 32'd0);
    applyStimulus(7);
    checkOutput("carry_hi", {32'd0, r_data[5]}, 64'h1);
    checkOutput("carry_lo", {32'd0, r_data[6]}, 64'h0);

    $display("[TB] prescale 3");
    setOp(0, 1'b1, 3'd0, 4'hF, 32'd0);
    setOp(1, 1'b1, 3'd1, 4'hF, 32'd0);
    setOp(2, 1'b1, 3'd4, 4'hF, 32'h0003_0001);
    applyStimulus(3);
    repeat (40) @(posedge clk);
    #1;
    setOp(0, 1'b0, 3'd0, 4'hF, 32'd0);
    applyStimulus(1);
    checkOutput("presc3_lo", {32'd0, r_data[0]}, 64'd10);

    $display("[TB] prescale 0");
    setOp(0, 1'b1, 3'd4, 4'hF, 32'h0000_0001);
    setOp(1, 1'b0, 3'd0, 4'hF, 32'd0);
    setOp(2, 1'b0, 3'd0, 4'hF, 32'd0);
    applyStimulus(3);
    checkOutput("presc0_step", {32'd0, r_data[2] - r_data[1]}, 64'd1);

    $display("[TB] write coincident with tick");
    setOp(0, 1'b0, 3'd1, 4'hF, 32'd0);
    setOp(1, 1'b1, 3'd0, 4'hF, 32'h0000_1234);
    setOp(2, 1'b0, 3'd0, 4'hF, 32'd0);
    setOp(3, 1'b0, 3'd1, 4'hF, 32'd0);
    applyStimulus(4);
    checkOutput("wr_tick_lo", {32'd0, r_data[2]}, 64'h1234);
    checkOutput("wr_tick_hi", {32'd0, r_data[3]}, {32'd0, r_data[0]});

    $display("[TB] interrupt");
    setOp(0, 1'b1, 3'd4, 4'hF, 32'h0000_0000);
    setOp(1, 1'b1, 3'd0, 4'hF, 32'd100);
    setOp(2, 1'b1, 3'd1, 4'hF, 32'd0);
    setOp(3, 1'b1, 3'd3, 4'hF, 32'd0);
    setOp(4, 1'b1, 3'd2, 4'hF, 32'd105);
    applyStimulus(5);
    checkOutput("irq_before", {63'd0, irq}, 64'd0);
    setOp(0, 1'b1, 3'd4, 4'hF, 32'h0000_0001);
    applyStimulus(1);
    cnt = 0;
    while (!irq && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("irq_latency", 64'(cnt), 64'd6);
    @(posedge clk); #1;
    setOp(0, 1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF);
    setOp(1, 1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF);
    applyStimulus(2);
    checkOutput("irq_cleared", {63'd0, irq}, 64'd0);

    $display("[TB] byte lanes and unmapped");
    setOp(0, 1'b1, 3'd2, 4'hF, 32'h0000_0000);
    setOp(1, 1'b1, 3'd2, 4'b0010, 32'hAABB_CCDD);
    setOp(2, 1'b0, 3'd2, 4'hF, 32'd0);
    setOp(3, 1'b1, 3'd6, 4'hF, 32'h1234_5678);
    setOp(4, 1'b0, 3'd6, 4'hF, 32'd0);
    setOp(5, 1'b1, 3'd3, 4'h0, 32'h0000_0000);
    setOp(6, 1'b0, 3'd3, 4'hF, 32'd0);
    applyStimulus(7);
    checkOutput("sel_lane1", {32'd0, r_data[2]}, 64'h0000_CC00);
    checkOutput("unmapped_rd", {32'd0, r_data[4]}, 64'h0);
    checkOutput("sel0_hi", {32'd0, r_data[6]}, 64'hFFFF_FFFF);
    checkOutput("lanes_acks", 64'(acks_seen), 64'd7);

    $display("[TB] back-to-back and dropped cycle");
    for (int i = 0; i < 4; i++) setOp(i, 1'b0, 3'(i), 4'hF, 32'd0);
    applyStimulus(4);
    checkOutput("b2b_acks", 64'(acks_seen), 64'd4);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    checkOutput("drop_ack", {63'd0, ack}, 64'd0);
    @(posedge clk); #1;

    $display("[TB] reset mid-run");
    rstn = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
    addr = 32'h0000_0008; sel = 4'hF; wdata = 32'h0000_0123;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_drop_ack", {63'd0, ack}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < 5; i++) setOp(i, 1'b0, 3'(i), 4'hF, 32'd0);
    applyStimulus(5);
    checkOutput("rst2_mtime_lo", {32'd0, r_data[0]}, 64'h0);
    checkOutput("rst2_cmp_lo",   {32'd0, r_data[2]}, 64'hFFFF_FFFF);
    checkOutput("rst2_ctrl",     {32'd0, r_data[4]}, 64'h0000_0001);
    checkOutput("rst2_irq",      {63'd0, irq}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
